mdr_operand_loader: RTL and testbench

MDR_OPERAND_LOADER -- requirements
Module: mdr_operand_loader

---
 rtl/mdr_operand_loader.sv | 139 +++++++++++++
 tb/tb_mdr_operand_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_operand_loader.sv
// Operand loader and sequencer for the MDR (mul/div/sqrt) engine: captures operands on
// load edges, validates them, starts the engine and latches its result or flags an error.
module mdr_operand_loader #(
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] data_in,
    input  logic [1:0]    op,
    input  logic          engine_ready,
    input  logic [DW-1:0] engine_q,
    input  logic [DW-1:0] engine_r,
    output logic          start_out,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic [1:0]    op_sel,
    output logic [DW-1:0] result_q,
    output logic [DW-1:0] result_r,
    output logic          result_valid,
    output logic          error,
    output logic          busy
);

    localparam int unsigned    TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT - 1);

    localparam logic [1:0] OpDiv  = 2'b01;
    localparam logic [1:0] OpSqrt = 2'b10;
    localparam logic [1:0] OpBad  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StLoadB,
        StCheck,
        StStart,
        StWait,
        StDone,
        StErr
    } state_e;

    state_e        state;
    logic          load_d;
    logic          rdy_d;
    logic [TW-1:0] timer;
    logic          load_rise;
    logic          rdy_rise;
    logic          bad_operand;

    assign load_rise   = load & ~load_d;
    assign rdy_rise    = engine_ready & ~rdy_d;
    assign bad_operand = ((op_sel == OpDiv) && (op_b == '0)) ||
                         ((op_sel == OpSqrt) && op_a[DW-1]);

    // Both are decoded from the registered state, so they only move on clk.
    assign start_out = (state == StStart);
    assign busy      = (state == StCheck) || (state == StStart) || (state == StWait);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= StIdle;
            load_d       <= 1'b0;
            rdy_d        <= 1'b1;
            timer        <= '0;
            op_a         <= '0;
            op_b         <= '0;
            op_sel       <= '0;
            result_q     <= '0;
            result_r     <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            load_d <= load;
            rdy_d  <= engine_ready;
            case (state)
                StIdle, StDone, StErr: begin
                    if (load_rise) begin
                        op_a         <= data_in;
                        op_sel       <= op;
                        op_b         <= '0;
                        result_valid <= 1'b0;
                        error        <= 1'b0;
                        if (op == OpSqrt) begin
                            state <= StCheck;
                        end else if (op == OpBad) begin
                            state    <= StErr;
                            error    <= 1'b1;
                            result_q <= '0;
                            result_r <= '0;
                        end else begin
                            state <= StLoadB;
                        end
                    end
                end
                StLoadB: begin
                    if (load_rise) begin
                        op_b  <= data_in;
                        state <= StCheck;
                    end
                end
                StCheck: begin
                    if (bad_operand) begin
                        state        <= StErr;
                        error        <= 1'b1;
                        result_q     <= '0;
                        result_r     <= '0;
                        result_valid <= 1'b0;
                    end else begin
                        state <= StStart;
                    end
                end
                StStart: begin
                    timer <= '0;
                    state <= StWait;
                end
                StWait: begin
                    // A ready edge takes priority over an expiring timer.
                    if (rdy_rise) begin
                        result_q     <= engine_q;
                        result_r     <= engine_r;
                        result_valid <= 1'b1;
                        state        <= StDone;
                    end else if (timer == TMAX) begin
                        state        <= StErr;
                        error        <= 1'b1;
                        result_q     <= '0;
                        result_r     <= '0;
                        result_valid <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_operand_loader.sv
// Self-checking bench for mdr_operand_loader: directed scenarios plus randomized transactions
// against a behavioural engine/loader model; a second instance runs with a short timeout.
module tb_mdr_operand_loader;

    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [DW-1:0] data_in;
    logic [1:0]    op;
    logic          engine_ready;
    logic [DW-1:0] engine_q;
    logic [DW-1:0] engine_r;

    logic          start_out, result_valid, error, busy;
    logic [DW-1:0] op_a, op_b, result_q, result_r;
    logic [1:0]    op_sel;

    logic          t_start_out, t_result_valid, t_error, t_busy;
    logic [DW-1:0] t_op_a, t_op_b, t_result_q, t_result_r;
    logic [1:0]    t_op_sel;

    int vectors     = 0;
    int miscompares = 0;
    int start_cnt   = 0;

    always #5 clk = ~clk;

    mdr_operand_loader #(.DW(DW), .TIMEOUT(1024)) u_dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .op(op),
        .engine_ready(engine_ready), .engine_q(engine_q), .engine_r(engine_r),
        .start_out(start_out), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
        .result_q(result_q), .result_r(result_r), .result_valid(result_valid),
        .error(error), .busy(busy)
    );

    mdr_operand_loader #(.DW(DW), .TIMEOUT(8)) u_dut8 (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .op(op),
        .engine_ready(engine_ready), .engine_q(engine_q), .engine_r(engine_r),
        .start_out(t_start_out), .op_a(t_op_a), .op_b(t_op_b), .op_sel(t_op_sel),
        .result_q(t_result_q), .result_r(t_result_r), .result_valid(t_result_valid),
        .error(t_error), .busy(t_busy)
    );

    // Counts cycles with start_out high, so a pulse wider than one cycle shows up.
    always @(negedge clk) if (start_out) start_cnt = start_cnt + 1;

    initial begin
        #2000000;
        $error("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_load(input logic [DW-1:0] d, input logic [1:0] o);
        data_in = d;
        op      = o;
        load    = 1'b1;
        tick();
        load = 1'b0;
        tick();
    endtask

    // Engine behaviour: MUL gives {hi,lo}, DIV gives quotient/remainder, SQRT gives root/rest.
    function automatic void engine_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [1:0] o,
                                         output logic [DW-1:0] q, output logic [DW-1:0] r);
        int unsigned ia, ib, root;
        ia = 32'(a);
        ib = 32'(b);
        q  = '0;
        r  = '0;
        case (o)
            2'b00: begin
                q = DW'(ia * ib);
                r = DW'((ia * ib) >> DW);
            end
            2'b01: if (ib != 0) begin
                q = DW'(ia / ib);
                r = DW'(ia % ib);
            end
            2'b10: begin
                root = 0;
                for (int i = 0; i < 256; i++) if (i * i <= int'(ia)) root = 32'(i);
                q = DW'(root);
                r = DW'(ia - root * root);
            end
            default: ;
        endcase
    endfunction

    task automatic run_txn(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] o,
                           input int delay, input int hold);
        logic [DW-1:0] q, r;
        logic          exp_err, two_loads;
        int            s0;
        two_loads = (o == 2'b00) || (o == 2'b01);
        exp_err   = (o == 2'b11) || (o == 2'b01 && b == 0) || (o == 2'b10 && a[DW-1]);
        engine_model(a, b, o, q, r);
        engine_ready = 1'b0;
        tick();
        s0 = start_cnt;
        pulse_load(a, o);
        if (two_loads) begin
            chk("opa_after_a", 32'(op_a), 32'(a));
            chk("opb_cleared", 32'(op_b), 32'(0));
            chk("busy_in_loadb", 32'(busy), 32'(0));
            chk("valid_cleared", 32'(result_valid), 32'(0));
            pulse_load(b, o);
        end
        if (exp_err) begin
            chk("err_flag", 32'(error), 32'(1));
            chk("err_opa", 32'(op_a), 32'(a));
            chk("err_valid", 32'(result_valid), 32'(0));
            chk("err_rq", 32'(result_q), 32'(0));
            chk("err_rr", 32'(result_r), 32'(0));
            chk("err_busy", 32'(busy), 32'(0));
        end else begin
            chk("start_high", 32'(start_out), 32'(1));
            chk("start_opa", 32'(op_a), 32'(a));
            chk("start_opb", 32'(op_b), two_loads ? 32'(b) : 32'(0));
            chk("start_opsel", 32'(op_sel), 32'(o));
            tick();
            chk("start_low", 32'(start_out), 32'(0));
            chk("wait_busy", 32'(busy), 32'(1));
            pulse_load(~a, 2'b11);
            chk("wait_opa_hold", 32'(op_a), 32'(a));
            chk("wait_err_low", 32'(error), 32'(0));
            repeat (delay - 2) tick();
            chk("wait_no_valid", 32'(result_valid), 32'(0));
            engine_q     = q;
            engine_r     = r;
            engine_ready = 1'b1;
            tick();
            chk("res_q", 32'(result_q), 32'(q));
            chk("res_r", 32'(result_r), 32'(r));
            chk("res_valid", 32'(result_valid), 32'(1));
            chk("res_busy", 32'(busy), 32'(0));
            chk("res_err", 32'(error), 32'(0));
            engine_q = ~q;
            engine_r = ~r;
            repeat (hold - 1) tick();
            chk("hold_one_capture", 32'(result_q), 32'(q));
            engine_ready = 1'b0;
        end
        tick();
        chk("start_pulses", 32'(start_cnt - s0), exp_err ? 32'(0) : 32'(1));
    endtask

    initial begin
        logic [DW-1:0] ra, rb;
        logic [1:0]    ro;
        rst          = 1'b0;
        load         = 1'b0;
        data_in      = '0;
        op           = '0;
        engine_ready = 1'b1;
        engine_q     = 16'h5a5a;
        engine_r     = 16'ha5a5;
        repeat (2) tick();
        chk("rst_start", 32'(start_out), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_valid", 32'(result_valid), 32'(0));
        chk("rst_error", 32'(error), 32'(0));
        chk("rst_opa", 32'(op_a), 32'(0));
        chk("rst_opsel", 32'(op_sel), 32'(0));
        chk("rst_rq", 32'(result_q), 32'(0));

        // Ready already high when reset releases: no capture while idle.
        rst = 1'b1;
        repeat (3) tick();
        chk("idle_rdy_valid", 32'(result_valid), 32'(0));
        chk("idle_rdy_rq", 32'(result_q), 32'(0));

        run_txn(16'd100, 16'd7, 2'b01, 20, 1);
        run_txn(16'd55, 16'd0, 2'b01, 5, 1);
        run_txn(16'd144, 16'd0, 2'b10, 10, 1);
        run_txn(16'h8000, 16'd0, 2'b10, 5, 1);
        run_txn(16'd1000, 16'd33, 2'b01, 8, 3);
        run_txn(16'd300, 16'd300, 2'b00, 6, 2);
        run_txn(16'd1, 16'd2, 2'b11, 5, 1);

        // Timeout on the short-timeout instance; the default one keeps waiting.
        rst = 1'b0;
        tick();
        rst          = 1'b1;
        engine_ready = 1'b0;
        pulse_load(16'd144, 2'b10);
        chk("to_start", 32'(t_start_out), 32'(1));
        tick();
        repeat (7) tick();
        chk("to_not_yet", 32'(t_error), 32'(0));
        chk("to_busy", 32'(t_busy), 32'(1));
        tick();
        chk("to_error", 32'(t_error), 32'(1));
        chk("to_idle_busy", 32'(t_busy), 32'(0));
        chk("to_valid", 32'(t_result_valid), 32'(0));
        pulse_load(16'h1234, 2'b00);
        chk("to_err_clear", 32'(t_error), 32'(0));
        chk("to_new_a", 32'(t_op_a), 32'(16'h1234));
        chk("long_still_busy", 32'(busy), 32'(1));
        chk("long_opa_hold", 32'(op_a), 32'(144));

        // Reset while the default instance is in WAIT.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_start", 32'(start_out), 32'(0));
        chk("midrst_valid", 32'(result_valid), 32'(0));
        chk("midrst_error", 32'(error), 32'(0));
        chk("midrst_opa", 32'(op_a), 32'(0));
        run_txn(16'd81, 16'd0, 2'b10, 4, 1);

        for (int n = 0; n < 20; n++) begin
            ra = 16'($urandom);
            ro = 2'($urandom_range(0, 3));
            rb = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            run_txn(ra, rb, ro, int'($urandom_range(3, 30)), int'($urandom_range(1, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
